// File: rtl/gyro_stream_pkg.sv
// Shared types and constants for the gyro stream packetizer.
// GYRO_STREAM_TIMESTAMP_EN selects the timestamped frame format.
package gyro_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_TS,
        ST_CH
    } state_e;

    localparam logic [3:0] REG_CTRL      = 4'h0;
    localparam logic [3:0] REG_DECIM     = 4'h4;
    localparam logic [3:0] REG_FRAME_CNT = 4'h8;
    localparam logic [3:0] REG_OVERRUN   = 4'hC;

    localparam logic [7:0] HDR_MAGIC    = 8'hA5;
    localparam logic [7:0] HDR_MAGIC_TS = 8'hA6;

    localparam int CH_IDX_LSB  = 28;
    localparam int CH_IDX_W    = 4;
    localparam int CH_SAMPLE_W = 28;

endpackage

// File: rtl/gyro_stream_axil_regs.sv
// AXI4-Lite slave and register file for the gyro stream packetizer.
// Single outstanding read and write; responses are always OKAY.
module gyro_stream_axil_regs
    import gyro_stream_pkg::*;
#(
    parameter int N_CH               = 3,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            enable,
    output logic [N_CH-1:0]                 ch_mask,
    output logic [15:0]                     decim,
    output logic                            ovr_clr,
    input  logic [15:0]                     frame_cnt,
    input  logic [15:0]                     overrun_cnt
);

    logic awready_q, awready_d;
    logic bvalid_q, bvalid_d;
    logic arready_q, arready_d;
    logic rvalid_q, rvalid_d;
    logic enable_q, enable_d;
    logic [N_CH-1:0] mask_q, mask_d;
    logic [15:0] decim_q, decim_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] rd_mux;
    logic [3:0] wr_off, rd_off;
    logic unused_ok;

    assign wr_off = S_AXI_AWADDR[3:0] & 4'hC;
    assign rd_off = S_AXI_ARADDR[3:0] & 4'hC;
    assign unused_ok = ^{S_AXI_WDATA, S_AXI_WSTRB};

    always_comb begin
        rd_mux = '0;
        case (rd_off)
            REG_CTRL:      rd_mux = 32'(enable_q) | (32'(mask_q) << 8);
            REG_DECIM:     rd_mux = 32'(decim_q);
            REG_FRAME_CNT: rd_mux = 32'(frame_cnt);
            REG_OVERRUN:   rd_mux = 32'(overrun_cnt);
            default:       rd_mux = '0;
        endcase
    end

    // The AW/W handshake completes in the cycle the ready pulse is high.
    always_comb begin
        awready_d = S_AXI_AWVALID && S_AXI_WVALID && !awready_q && !bvalid_q;
        bvalid_d  = bvalid_q ? !S_AXI_BREADY : awready_q;
        arready_d = S_AXI_ARVALID && !arready_q && !rvalid_q;
        rvalid_d  = rvalid_q ? !S_AXI_RREADY : arready_q;
        rdata_d   = arready_q ? rd_mux : rdata_q;
        enable_d  = enable_q;
        mask_d    = mask_q;
        decim_d   = decim_q;
        if (awready_q) begin
            case (wr_off)
                REG_CTRL: begin
                    if (S_AXI_WSTRB[0]) enable_d = S_AXI_WDATA[0];
                    if (S_AXI_WSTRB[1]) mask_d = S_AXI_WDATA[8 +: N_CH];
                end
                REG_DECIM: begin
                    if (S_AXI_WSTRB[0]) decim_d[7:0] = S_AXI_WDATA[7:0];
                    if (S_AXI_WSTRB[1]) decim_d[15:8] = S_AXI_WDATA[15:8];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            enable_q  <= 1'b0;
            mask_q    <= '0;
            decim_q   <= '0;
        end else begin
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            enable_q  <= enable_d;
            mask_q    <= mask_d;
            decim_q   <= decim_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign enable        = enable_q;
    assign ch_mask       = mask_q;
    assign decim         = decim_q;
    assign ovr_clr       = awready_q && (wr_off == REG_OVERRUN);

endmodule

// File: rtl/gyro_stream_packetizer.sv
// Decimates gyro samples and frames them as AXI-Stream packets.
// Define GYRO_STREAM_TIMESTAMP_EN to add a cycle-count timestamp beat.
module gyro_stream_packetizer
    import gyro_stream_pkg::*;
#(
    parameter int N_CH                 = 3,
    parameter int SAMPLE_W             = 16,
    parameter int C_S_AXI_DATA_WIDTH   = 32,
    parameter int C_S_AXI_ADDR_WIDTH   = 4,
    parameter int C_M_AXIS_TDATA_WIDTH = 32
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic                            sample_valid,
    input  logic [N_CH*SAMPLE_W-1:0]        sample_data,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                            M_AXIS_TLAST,
    input  logic                            M_AXIS_TREADY,
    output logic                            irq_overrun
);

    logic enable, ovr_clr;
    logic [N_CH-1:0] ch_mask;
    logic [15:0] decim;

    state_e state_q, state_d;
    logic [15:0] dec_cnt_q, dec_cnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] ovr_cnt_q, ovr_cnt_d;
    logic [N_CH*SAMPLE_W-1:0] cap_q, cap_d;
    logic [N_CH-1:0] rem_q, rem_d, rem_nxt;
    logic tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic [31:0] tdata_q, tdata_d;
    logic [3:0] nxt_idx;
    logic eligible, fire, advance;
`ifdef GYRO_STREAM_TIMESTAMP_EN
    logic [31:0] cyc_q, cyc_d, ts_q, ts_d;
`endif

    gyro_stream_axil_regs #(
        .N_CH               (N_CH),
        .C_S_AXI_DATA_WIDTH (C_S_AXI_DATA_WIDTH),
        .C_S_AXI_ADDR_WIDTH (C_S_AXI_ADDR_WIDTH)
    ) u_regs (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .enable        (enable),
        .ch_mask       (ch_mask),
        .decim         (decim),
        .ovr_clr       (ovr_clr),
        .frame_cnt     (frame_cnt_q),
        .overrun_cnt   (ovr_cnt_q)
    );

    function automatic logic [31:0] ch_beat(logic [3:0] idx, logic [SAMPLE_W-1:0] s);
        return {idx, {(CH_SAMPLE_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
    endfunction

    // rem_q holds channels still to send; the lowest set bit goes next.
    always_comb begin
        nxt_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rem_q[i]) nxt_idx = 4'(i);
        end
        rem_nxt = rem_q & ~(N_CH'(1) << nxt_idx);
    end

    always_comb begin
        eligible    = sample_valid && enable && (dec_cnt_q == 16'd0);
        fire        = tvalid_q && M_AXIS_TREADY;
        dec_cnt_d   = dec_cnt_q;
        frame_cnt_d = frame_cnt_q;
        ovr_cnt_d   = ovr_cnt_q;
        if (!enable) dec_cnt_d = '0;
        else if (sample_valid) dec_cnt_d = (dec_cnt_q >= decim) ? 16'd0 : dec_cnt_q + 16'd1;
        if (fire && tlast_q) frame_cnt_d = frame_cnt_q + 16'd1;
        if (ovr_clr) ovr_cnt_d = '0;
        else if (eligible && state_q != ST_IDLE && ovr_cnt_q != 16'hFFFF)
            ovr_cnt_d = ovr_cnt_q + 16'd1;
    end

    always_comb begin
        state_d  = state_q;
        cap_d    = cap_q;
        rem_d    = rem_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tdata_d  = tdata_q;
        advance  = 1'b0;
`ifdef GYRO_STREAM_TIMESTAMP_EN
        cyc_d    = cyc_q + 32'd1;
        ts_d     = ts_q;
`endif
        unique case (state_q)
            ST_IDLE: if (eligible) begin
                cap_d    = sample_data;
                rem_d    = ch_mask;
                tvalid_d = 1'b1;
                state_d  = ST_HDR;
`ifdef GYRO_STREAM_TIMESTAMP_EN
                ts_d     = cyc_q;
                tdata_d  = {HDR_MAGIC_TS, 8'(ch_mask), frame_cnt_q};
                tlast_d  = 1'b0;
`else
                tdata_d  = {HDR_MAGIC, 8'(ch_mask), frame_cnt_q};
                tlast_d  = (ch_mask == '0);
`endif
            end
`ifdef GYRO_STREAM_TIMESTAMP_EN
            ST_HDR: if (fire) begin
                state_d = ST_TS;
                tdata_d = ts_q;
                tlast_d = (rem_q == '0);
            end
`endif
            default: advance = fire;
        endcase
        if (advance) begin
            if (rem_q == '0) begin
                state_d  = ST_IDLE;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end else begin
                state_d = ST_CH;
                rem_d   = rem_nxt;
                tlast_d = (rem_nxt == '0);
                tdata_d = ch_beat(nxt_idx, cap_q[nxt_idx*SAMPLE_W +: SAMPLE_W]);
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= ST_IDLE;
            dec_cnt_q   <= '0;
            frame_cnt_q <= '0;
            ovr_cnt_q   <= '0;
            cap_q       <= '0;
            rem_q       <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= '0;
`ifdef GYRO_STREAM_TIMESTAMP_EN
            cyc_q       <= '0;
            ts_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            dec_cnt_q   <= dec_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            ovr_cnt_q   <= ovr_cnt_d;
            cap_q       <= cap_d;
            rem_q       <= rem_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tdata_q     <= tdata_d;
`ifdef GYRO_STREAM_TIMESTAMP_EN
            cyc_q       <= cyc_d;
            ts_q        <= ts_d;
`endif
        end
    end

    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TLAST  = tlast_q;
    assign irq_overrun   = (ovr_cnt_q != 16'd0);

endmodule
